// File: rtl/skew_feeder.sv
// skew_feeder: operand skew stage for the matmul systolic array.
//
// Accepts a tile of K operand vectors, one N-lane vector per handshake, and
// re-emits them diagonally staggered. Lane i is delayed by i steps, so lane i
// of every vector reaches array edge i one step after lane i-1. Ramp-up and
// ramp-down triangles are zero-filled and flagged invalid in out_lane_valid.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   start, len      begin a tile of len vectors (sampled only in IDLE, len != 0)
//   in_valid        upstream vector valid
//   in_ready        high while streaming the tile's input vectors
//   in_data         N lanes of DW bits, lane i at [i*DW +: DW]
//   out_valid       one skewed output step is presented this cycle
//   out_data        skewed lanes, same packing as in_data (held when idle)
//   out_lane_valid  bit i: lane i carries a real element this step
//   busy            a tile is in progress
//   done            pulse on the final output step of a tile
module skew_feeder #(
    parameter int N  = 16,
    parameter int DW = 16,
    parameter int LW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LW-1:0]   len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
    output logic            out_valid,
    output logic [N*DW-1:0] out_data,
    output logic [N-1:0]    out_lane_valid,
    output logic            busy,
    output logic            done
);

    localparam int            FW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'((N > 1) ? (N - 2) : 0);
    localparam bit            MULTI_LANE = (N > 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [LW-1:0]   k_r;
    logic [LW-1:0]   acc_r;
    logic [FW-1:0]   flush_r;

    logic            start_ok_s;
    logic            accept_s;
    logic            step_s;
    logic            acc_last_s;
    logic            flush_last_s;
    logic            last_step_s;

    // Each lane element travels as {valid, data}.
    logic [DW:0]     lane_in_s [N];
    logic [DW:0]     tail_s    [N];
    logic [N*DW-1:0] tail_data_s;
    logic [N-1:0]    tail_mask_s;

    assign in_ready = (state_r == STREAM);
    assign busy     = (state_r != IDLE);

    // Step qualification: a step is an accepted vector or any FLUSH cycle.
    always_comb begin
        start_ok_s   = start && (len != '0);
        accept_s     = (state_r == STREAM) && in_valid;
        step_s       = accept_s || (state_r == FLUSH);
        acc_last_s   = (acc_r == (k_r - LW'(1)));
        flush_last_s = (flush_r == FLUSH_LAST);
        // With a single lane there is no ramp-down, so the last accept ends the tile.
        if (MULTI_LANE) begin
            last_step_s = (state_r == FLUSH) && flush_last_s;
        end else begin
            last_step_s = accept_s && acc_last_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (accept_s && acc_last_s) begin
                    if (MULTI_LANE) begin
                        state_nxt_s = FLUSH;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            FLUSH: begin
                if (flush_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Tile length latch plus accept and flush counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r     <= '0;
            acc_r   <= '0;
            flush_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        k_r   <= len;
                        acc_r <= '0;
                    end
                end
                STREAM: begin
                    flush_r <= '0;
                    if (accept_s) begin
                        acc_r <= acc_r + LW'(1);
                    end
                end
                FLUSH: begin
                    flush_r <= flush_r + FW'(1);
                end
                default: begin
                    acc_r   <= '0;
                    flush_r <= '0;
                end
            endcase
        end
    end

    // Lane inputs: real elements while streaming, zero bubbles while flushing.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (state_r == STREAM) begin
                lane_in_s[i] = {1'b1, in_data[i*DW +: DW]};
            end else begin
                lane_in_s[i] = '0;
            end
        end
    end

    // Skew array: lane i is an i-deep shift register; lane 0 feeds the output directly.
    for (genvar i = 0; i < N; i++) begin : g_lane
        if (i == 0) begin : g_direct
            assign tail_s[i] = lane_in_s[i];
        end else begin : g_shift
            logic [DW:0] sr [i];

            // Shift the lane by one position on every step, hold otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < i; j++) begin
                        sr[j] <= '0;
                    end
                end else if (step_s) begin
                    sr[0] <= lane_in_s[i];
                    for (int j = 1; j < i; j++) begin
                        sr[j] <= sr[j-1];
                    end
                end
            end

            assign tail_s[i] = sr[i-1];
        end
    end

    // Split lane tails into the packed data word and the valid mask.
    always_comb begin
        tail_data_s = '0;
        tail_mask_s = '0;
        for (int i = 0; i < N; i++) begin
            tail_data_s[i*DW +: DW] = tail_s[i][DW-1:0];
            tail_mask_s[i]          = tail_s[i][DW];
        end
    end

    // Output register: loads on a step, data and mask hold between steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            done           <= 1'b0;
            out_data       <= '0;
            out_lane_valid <= '0;
        end else begin
            out_valid <= step_s;
            done      <= last_step_s;
            if (step_s) begin
                out_data       <= tail_data_s;
                out_lane_valid <= tail_mask_s;
            end
        end
    end

endmodule

// File: tb/tb_skew_feeder.sv
// Testbench for skew_feeder: a 4-lane and a 1-lane instance, directed tiles,
// scoreboard queues filled at stimulus time and drained by a negedge monitor.
module tb_skew_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        start4, in_valid4, in_ready4, out_valid4, busy4, done4;
    logic [7:0]  len4;
    logic [63:0] in_data4, out_data4;
    logic [3:0]  out_lane_valid4;

    logic        start1, in_valid1, in_ready1, out_valid1, busy1, done1;
    logic [7:0]  len1;
    logic [15:0] in_data1, out_data1;
    logic [0:0]  out_lane_valid1;

    skew_feeder #(.N(4), .DW(16), .LW(8)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .len(len4),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_data(out_data4),
        .out_lane_valid(out_lane_valid4), .busy(busy4), .done(done4)
    );

    skew_feeder #(.N(1), .DW(16), .LW(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(len1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_data(out_data1),
        .out_lane_valid(out_lane_valid1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [3:0]  mask;
        logic [63:0] data;
        logic        done;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   ov_cyc4[$];
    int   ov_cyc1[$];
    int   done_cyc4 = -1;
    int   done_cyc1 = -1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Lane i of vector v in tile t: nonzero so zero fill is distinguishable.
    function automatic logic [63:0] vec4(input int tile, input int v);
        logic [63:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*16 +: 16] = 16'hA000 | 16'((tile & 15) << 8) | 16'((v & 15) << 4) | 16'(i);
        end
        return r;
    endfunction

    // Expected output step t: lane i valid iff i <= t < i+K, carrying vector t-i.
    task automatic push_tile4(input int tile, input int k, input int trunc);
        exp_t        e;
        logic [63:0] vv;
        for (int t = 0; t < k + 3 && t < trunc; t++) begin
            e = '0;
            for (int i = 0; i < 4; i++) begin
                if (i <= t && t < i + k) begin
                    e.mask[i] = 1'b1;
                    vv = vec4(tile, t - i);
                    e.data[i*16 +: 16] = vv[i*16 +: 16];
                end
            end
            e.done = (t == k + 2);
            q4.push_back(e);
        end
    endtask

    // Monitor: pop and compare whenever a DUT presents an output step.
    always @(negedge clk) begin
        if (out_valid4) begin
            ov_cyc4.push_back(cyc);
            if (done4) done_cyc4 = cyc;
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4 unexpected out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e4 = q4.pop_front();
                check("dut4 lane mask", 64'(out_lane_valid4), 64'(e4.mask));
                check("dut4 data", out_data4, e4.data);
                check("dut4 done", 64'(done4), 64'(e4.done));
            end
        end
        if (done4 && !out_valid4) check("dut4 done without out_valid", 64'(done4), 64'd0);
        if (done4) check("dut4 idle in done cycle", 64'(busy4), 64'd0);

        if (out_valid1) begin
            ov_cyc1.push_back(cyc);
            if (done1) done_cyc1 = cyc;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1 unexpected out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1 lane mask", 64'(out_lane_valid1), 64'(e1.mask[0]));
                check("dut1 data", 64'(out_data1), 64'(e1.data[15:0]));
                check("dut1 done", 64'(done1), 64'(e1.done));
            end
        end
        if (done1) check("dut1 idle in done cycle", 64'(busy1), 64'd0);
    end

    // Issue one tile on the 4-lane DUT; caller is positioned just after an edge.
    task automatic tile4(input int tile, input int k, input int gap_at, input int gap_len,
                         input bit poke, input int trunc, output int c0);
        start4 = 1'b1;
        len4   = 8'(k);
        c0     = cyc + 1;
        push_tile4(tile, k, trunc);
        @(posedge clk); #1;
        start4 = 1'b0;
        len4   = 8'd0;
        for (int v = 0; v < k; v++) begin
            if (v == gap_at) begin
                in_valid4 = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            check("dut4 in_ready while streaming", 64'(in_ready4), 64'd1);
            in_valid4 = 1'b1;
            in_data4  = vec4(tile, v);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        in_data4  = '0;
        if (poke) begin
            start4 = 1'b1;
            len4   = 8'd5;
            @(posedge clk); #1;
            start4 = 1'b0;
            len4   = 8'd0;
        end
    endtask

    task automatic wait_idle4();
        int n;
        n = 0;
        while (busy4 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("dut4 returns to idle", 64'(busy4), 64'd0);
        @(posedge clk); #1;
    endtask

    // Output step j appears at c0+1+j, shifted by gap_len once the gap is hit.
    task automatic verify4(input string name, input int c0, input int k,
                           input int gap_at, input int gap_len);
        int nsteps;
        int extra;
        nsteps = k + 3;
        extra  = (gap_at >= 0) ? gap_len : 0;
        check({name, " step count"}, 64'(ov_cyc4.size()), 64'(nsteps));
        for (int j = 0; j < ov_cyc4.size() && j < nsteps; j++) begin
            check({name, " step cycle"}, 64'(ov_cyc4[j]),
                  64'(c0 + 1 + j + ((gap_at >= 0 && j >= gap_at) ? gap_len : 0)));
        end
        check({name, " done cycle"}, 64'(done_cyc4), 64'(c0 + k + 3 + extra));
        check({name, " scoreboard drained"}, 64'(q4.size()), 64'd0);
        ov_cyc4.delete();
        done_cyc4 = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, n;
        rst = 1'b1;
        start4 = 1'b0; len4 = 8'd0; in_valid4 = 1'b0; in_data4 = '0;
        start1 = 1'b0; len1 = 8'd0; in_valid1 = 1'b0; in_data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(out_valid4), 64'd0);
        check("reset out_data", out_data4, 64'd0);
        check("reset out_lane_valid", 64'(out_lane_valid4), 64'd0);
        check("reset done", 64'(done4), 64'd0);
        check("reset busy", 64'(busy4), 64'd0);
        check("reset in_ready", 64'(in_ready4), 64'd0);
        check("reset dut1 busy", 64'(busy1), 64'd0);
        check("reset dut1 in_ready", 64'(in_ready1), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic tile, K=3.
        tile4(1, 3, -1, 0, 1'b0, 99, c0);
        wait_idle4();
        verify4("basic", c0, 3, -1, 0);

        // Upstream gap of two cycles before the third vector; stray start in FLUSH.
        tile4(2, 3, 2, 2, 1'b1, 99, c0);
        wait_idle4();
        verify4("gap", c0, 3, 2, 2);

        // Single vector on four lanes.
        tile4(3, 1, -1, 0, 1'b0, 99, c0);
        wait_idle4();
        verify4("single", c0, 1, -1, 0);

        // start with len=0 is ignored.
        start4 = 1'b1;
        len4   = 8'd0;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0 busy", 64'(busy4), 64'd0);
            @(posedge clk); #1;
        end
        check("len0 no output", 64'(ov_cyc4.size()), 64'd0);
        check("len0 no done", 64'(done_cyc4), 64'hFFFF_FFFF_FFFF_FFFF);

        // Single lane, K=2: no FLUSH, done on the second step.
        start1 = 1'b1;
        len1   = 8'd2;
        c0     = cyc + 1;
        for (int v = 0; v < 2; v++) begin
            e1 = '0;
            e1.mask = 4'b0001;
            e1.data = {48'd0, 16'hB000 | 16'(v)};
            e1.done = (v == 1);
            q1.push_back(e1);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        len1   = 8'd0;
        for (int v = 0; v < 2; v++) begin
            check("dut1 in_ready", 64'(in_ready1), 64'd1);
            in_valid1 = 1'b1;
            in_data1  = 16'hB000 | 16'(v);
            @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
        in_data1  = '0;
        check("dut1 idle after last accept", 64'(busy1), 64'd0);
        @(posedge clk); #1;
        check("dut1 step count", 64'(ov_cyc1.size()), 64'd2);
        if (ov_cyc1.size() == 2) begin
            check("dut1 first step cycle", 64'(ov_cyc1[0]), 64'(c0 + 1));
            check("dut1 second step cycle", 64'(ov_cyc1[1]), 64'(c0 + 2));
        end
        check("dut1 done cycle", 64'(done_cyc1), 64'(c0 + 2));
        check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);

        // Reset during FLUSH, raised while the 5th output step is presented.
        tile4(5, 3, -1, 0, 1'b0, 5, c0);
        n = 0;
        while (cyc < c0 + 5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midreset out_valid", 64'(out_valid4), 64'd0);
        check("midreset out_data", out_data4, 64'd0);
        check("midreset out_lane_valid", 64'(out_lane_valid4), 64'd0);
        check("midreset done", 64'(done4), 64'd0);
        check("midreset in_ready", 64'(in_ready4), 64'd0);
        check("midreset busy", 64'(busy4), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset steps before reset", 64'(ov_cyc4.size()), 64'd5);
        check("midreset no done", 64'(done_cyc4), 64'hFFFF_FFFF_FFFF_FFFF);
        check("midreset scoreboard drained", 64'(q4.size()), 64'd0);
        ov_cyc4.delete();
        tile4(6, 2, -1, 0, 1'b0, 99, c0);
        wait_idle4();
        verify4("after reset", c0, 2, -1, 0);

        // Back-to-back: second start raised in the done cycle of the first tile.
        tile4(7, 2, -1, 0, 1'b0, 99, c0);
        n = 0;
        while (cyc < c0 + 5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b done visible", 64'(done4), 64'd1);
        tile4(8, 3, -1, 0, 1'b0, 99, c1);
        check("b2b start accepted", 64'(c1), 64'(c0 + 6));
        wait_idle4();
        check("b2b step count", 64'(ov_cyc4.size()), 64'd11);
        if (ov_cyc4.size() == 11) begin
            check("b2b second tile first step", 64'(ov_cyc4[5]), 64'(c1 + 1));
        end
        check("b2b done cycle", 64'(done_cyc4), 64'(c1 + 6));
        check("b2b scoreboard drained", 64'(q4.size()), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check("final dut4 scoreboard", 64'(q4.size()), 64'd0);
        check("final dut1 scoreboard", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
